// File: rtl/pid_pkg.sv
// Shared definitions for the servomotor PID datapath: default widths,
// saturation limits of the default Q10.15 word and the sequencer state encoding.
package pid_pkg;

  localparam int N_DEF = 25;
  localparam int F_DEF = 15;

  // Saturation is symmetric: the most negative code is never produced by clamping.
  localparam logic signed [N_DEF-1:0] SAT_MAX = {1'b0, {(N_DEF-1){1'b1}}};
  localparam logic signed [N_DEF-1:0] SAT_MIN = {1'b1, {(N_DEF-2){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    REPOSO = 3'd0,
    T0     = 3'd1,
    T1     = 3'd2,
    T2     = 3'd3,
    FIN    = 3'd4
  } estado_t;

endpackage

// File: rtl/multiplicacion_sat.sv
// Combinational fixed-point multiply with floor rescaling and symmetric
// saturation to +/-(2^(N-1)-1); shared with the filter stages.
module multiplicacion_sat
  import pid_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int F = F_DEF
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] p
);

  localparam logic signed [2*N-1:0] MAX_W = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] MIN_W = -MAX_W;

  logic signed [2*N-1:0] prod_s;
  logic signed [2*N-1:0] escalado_s;

  // full-precision product, rescaled by F with an arithmetic shift, then clamped
  always_comb begin
    prod_s     = a * b;
    escalado_s = prod_s >>> F;
    if (escalado_s > MAX_W) begin
      p = MAX_W[N-1:0];
    end else if (escalado_s < MIN_W) begin
      p = MIN_W[N-1:0];
    end else begin
      p = escalado_s[N-1:0];
    end
  end

endmodule

// File: rtl/suma_sat.sv
// Saturating two's-complement adder; only same-sign overflow is clamped,
// so a raw -2^(N-1) result passes through untouched.
module suma_sat
  import pid_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] s
);

  localparam logic signed [N-1:0] MAX_V = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] MIN_V = {1'b1, {(N-2){1'b0}}, 1'b1};

  logic signed [N-1:0] crudo_s;

  // raw sum with overflow detection from operand and result signs
  always_comb begin
    crudo_s = a + b;
    if (!a[N-1] && !b[N-1] && crudo_s[N-1]) begin
      s = MAX_V;
    end else if (a[N-1] && b[N-1] && !crudo_s[N-1]) begin
      s = MIN_V;
    end else begin
      s = crudo_s;
    end
  end

endmodule

// File: rtl/control_pid_secuencial.sv
// Velocity-form PID: U[n] = U[n-1] + K0*e[n] + K1*e[n-1] + K2*e[n-2],
// one shared multiplier and adder stepped by a 4-cycle sequencer.
module control_pid_secuencial
  import pid_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int F = F_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inicio,
  input  logic signed [N-1:0] error,
  input  logic signed [N-1:0] K0,
  input  logic signed [N-1:0] K1,
  input  logic signed [N-1:0] K2,
  output logic                listo,
  output logic                valido,
  output logic signed [N-1:0] U
);

  estado_t estado_r, estado_s;

  logic signed [N-1:0] e0_r, e1_r, e2_r, acc_r;
  logic signed [N-1:0] ganancia_s, muestra_s, prod_s, suma_s, acc_d_s;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_r <= REPOSO;
    end else begin
      estado_r <= estado_s;
    end
  end

  // next-state logic; strobes outside REPOSO are dropped
  always_comb begin
    estado_s = REPOSO;
    case (estado_r)
      REPOSO: begin
        if (inicio) begin
          estado_s = T0;
        end else begin
          estado_s = REPOSO;
        end
      end
      T0:      estado_s = T1;
      T1:      estado_s = T2;
      T2:      estado_s = FIN;
      FIN:     estado_s = REPOSO;
      default: estado_s = REPOSO;
    endcase
  end

  // operand selection for the shared multiplier, fixed order K0, K1, K2
  always_comb begin
    ganancia_s = {N{1'b0}};
    muestra_s  = {N{1'b0}};
    case (estado_r)
      T0: begin
        ganancia_s = K0;
        muestra_s  = e0_r;
      end
      T1: begin
        ganancia_s = K1;
        muestra_s  = e1_r;
      end
      T2: begin
        ganancia_s = K2;
        muestra_s  = e2_r;
      end
      default: begin
        ganancia_s = {N{1'b0}};
        muestra_s  = {N{1'b0}};
      end
    endcase
  end

  multiplicacion_sat #(.N(N), .F(F)) u_mul (
    .a (ganancia_s),
    .b (muestra_s),
    .p (prod_s)
  );

  suma_sat #(.N(N)) u_suma (
    .a (acc_r),
    .b (prod_s),
    .s (suma_s)
  );

  // accumulator D input: seeded with U on an accepted strobe, adder output while summing
  always_comb begin
    acc_d_s = acc_r;
    if (estado_r == REPOSO) begin
      if (inicio) begin
        acc_d_s = U;
      end else begin
        acc_d_s = acc_r;
      end
    end else if ((estado_r == T0) || (estado_r == T1) || (estado_r == T2)) begin
      acc_d_s = suma_s;
    end else begin
      acc_d_s = acc_r;
    end
  end

  // datapath and output registers; history shifts only when a sample completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e0_r   <= {N{1'b0}};
      e1_r   <= {N{1'b0}};
      e2_r   <= {N{1'b0}};
      acc_r  <= {N{1'b0}};
      U      <= {N{1'b0}};
      valido <= 1'b0;
      listo  <= 1'b1;
    end else begin
      acc_r  <= acc_d_s;
      valido <= (estado_r == FIN);
      listo  <= (estado_s == REPOSO);
      if ((estado_r == REPOSO) && inicio) begin
        e0_r <= error;
      end
      if (estado_r == FIN) begin
        U    <= acc_r;
        e1_r <= e0_r;
        e2_r <= e1_r;
      end
    end
  end

endmodule

// File: tb/tb_control_pid_secuencial.sv
// Directed bench for control_pid_secuencial: latency, history, rescaling,
// saturation, busy-strobe rejection and asynchronous reset abort.
module tb_control_pid_secuencial;
  import pid_pkg::*;

  localparam int N = N_DEF;
  localparam int F = F_DEF;

  logic                clk = 1'b0;
  logic                reset;
  logic                inicio;
  logic signed [N-1:0] error, K0, K1, K2;
  logic                listo, valido;
  logic signed [N-1:0] U;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valido;

  always #5 clk = ~clk;

  control_pid_secuencial #(.N(N), .F(F)) dut (
    .clk    (clk),
    .reset  (reset),
    .inicio (inicio),
    .error  (error),
    .K0     (K0),
    .K1     (K1),
    .K2     (K2),
    .listo  (listo),
    .valido (valido),
    .U      (U)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // one strobe, fixed 4-cycle latency, U compared on the valido cycle
  task automatic do_sample(input string tag, input longint err, input longint exp_u);
    check({tag, "_listo_pre"}, longint'(listo), 1);
    error  = N'(err);
    inicio = 1'b1;
    @(posedge clk);
    #1 inicio = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check({tag, "_busy"}, longint'({listo, valido}), 0);
      @(posedge clk);
      #1;
    end
    check({tag, "_busy_fin"}, longint'({listo, valido}), 0);
    @(posedge clk);
    #1;
    check({tag, "_valido"}, longint'(valido), 1);
    check({tag, "_listo"}, longint'(listo), 1);
    check({tag, "_U"}, longint'(U), exp_u);
  endtask

  initial begin
    reset = 1'b1; inicio = 1'b0; error = '0;
    K0 = '0; K1 = '0; K2 = '0;
    apply_reset();
    check("rst_U", longint'(U), 0);
    check("rst_listo", longint'(listo), 1);
    check("rst_valido", longint'(valido), 0);

    // unity K0, back-to-back samples (second strobe in the valido cycle)
    K0 = 25'sd32768;
    do_sample("k0_a", 100, 100);
    do_sample("k0_b", 100, 200);

    // K1 history
    apply_reset();
    K0 = '0; K1 = 25'sd32768; K2 = '0;
    do_sample("k1_a", 10, 0);
    do_sample("k1_b", 20, 10);
    do_sample("k1_c", 30, 30);

    // K2 history
    apply_reset();
    K1 = '0; K2 = 25'sd32768;
    do_sample("k2_a", 10, 0);
    do_sample("k2_b", 20, 0);
    do_sample("k2_c", 30, 10);

    // floor rescaling: 0.5 * -3 = -1.5 -> -2
    apply_reset();
    K0 = 25'sd16384; K1 = '0; K2 = '0;
    do_sample("frac", -3, -2);

    // product and sum saturation
    apply_reset();
    K0 = 25'sd16777215;
    do_sample("ovf_pos", 16777215, 16777215);
    do_sample("ovf_cancel", -16777215, 0);
    do_sample("ovf_neg", -16777215, -16777215);
    do_sample("ovf_neg_hold", -16777215, -16777215);

    // strobes in T0 and T2 must be ignored
    apply_reset();
    K0 = 25'sd32768; K1 = 25'sd32768; K2 = '0;
    error = 25'sd5; inicio = 1'b1;
    @(posedge clk);
    #1 error = 25'sd77;
    @(posedge clk);
    #1 inicio = 1'b0;
    @(posedge clk);
    #1 inicio = 1'b1;
    @(posedge clk);
    #1 inicio = 1'b0;
    n_valido = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (valido) n_valido++;
      if (i == 0) check("busy_U", longint'(U), 5);
    end
    check("busy_valido_count", longint'(n_valido), 1);
    check("busy_listo_idle", longint'(listo), 1);
    do_sample("busy_next", 7, 17);

    // asynchronous reset in T1 aborts the sample and clears history
    apply_reset();
    K0 = 25'sd32768; K1 = 25'sd32768; K2 = '0;
    do_sample("ar_pre", 50, 50);
    error = 25'sd60; inicio = 1'b1;
    @(posedge clk);
    #1 inicio = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("ar_U", longint'(U), 0);
    check("ar_listo", longint'(listo), 1);
    check("ar_valido", longint'(valido), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    do_sample("ar_post", 8, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_pid_secuencial.md
Name: control_pid_secuencial

Overview:
- Incremental (velocity-form) PID stage for the servomotor controller: U[n] = U[n-1] + K0*e[n] + K1*e[n-1] + K2*e[n-2].
- Signed fixed-point, N bits wide with F fractional bits.
- Uses one saturating multiplier and one saturating adder, time-multiplexed by an FSM, so one sample takes 4 cycles.
- Sits between the error computation (setpoint minus position) and the PWM duty generator, which consumes U.

Parameters:
- N, 25, word width of all data ports and internal registers (two's complement).
- F, 15, fractional bits of the Q(N-F).F format; 1.0 = 2^F = 32768.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- inicio  input  1  sample strobe: start processing the value on error. Honoured only when listo=1.
- error  input  N  signed e[n], captured on an accepted inicio.
- K0  input  N  signed gain on e[n]. Must be held stable while listo=0.
- K1  input  N  signed gain on e[n-1]. Must be held stable while listo=0.
- K2  input  N  signed gain on e[n-2]. Must be held stable while listo=0.
- listo  output  1  1 = idle and ready to accept inicio.
- valido  output  1  one-cycle pulse when U is updated.
- U  output  N  signed controller output, registered, held between samples.

Behaviour:
- Reset (async, active-high) values: U=0, valido=0, listo=1, e0=e1=e2=0, acc=0, FSM in REPOSO. These take effect immediately, whatever the FSM state.
- Reset mid-operation aborts the sample. History is cleared. No valido is produced.
- FSM states: REPOSO, T0, T1, T2, FIN.
- REPOSO: listo=1. On inicio=1, at the clock edge: e0<=error, acc<=U, go to T0.
- T0: acc <= sat_add(acc, sat_mul(K0,e0)). Go to T1.
- T1: acc <= sat_add(acc, sat_mul(K1,e1)). Go to T2.
- T2: acc <= sat_add(acc, sat_mul(K2,e2)). Go to FIN.
- FIN: U<=acc, valido<=1 (for the next cycle only), e2<=e1, e1<=e0. Go to REPOSO.
- listo=0 in T0, T1, T2 and FIN.
- Latency: inicio sampled at edge k. U and valido change at edge k+4. valido is high for exactly one cycle. listo returns to 1 in the same cycle valido is high.
- A new inicio asserted in that same cycle is accepted, so the maximum rate is one sample per 4 cycles.
- inicio while listo=0 is ignored. No queuing, no error flag.
- sat_mul(a,b):
  - Form the full 2N-bit signed product.
  - Arithmetic shift right by F (truncation toward -infinity).
  - If the result is > 2^(N-1)-1, output 2^(N-1)-1.
  - If the result is < -(2^(N-1)-1), output -(2^(N-1)-1).
  - Otherwise output the low N bits.
- sat_add(a,b):
  - Raw N-bit sum.
  - a>=0, b>=0 and raw negative -> +(2^(N-1)-1).
  - a<0, b<0 and raw >=0 -> -(2^(N-1)-1).
  - Otherwise the raw sum passes unchanged, including -2^(N-1).
- Saturation is applied at every term, not only at the end. Order of terms is fixed: K0, then K1, then K2.
- Gains changing while listo=0 give undefined results for that sample only. The FSM must still complete normally.
- No combinational path from any input to any output.

Decomposition:
- Shared package pid_pkg holds:
  - defaults N_DEF=25, F_DEF=15;
  - constants SAT_MAX = 2^(N-1)-1 and SAT_MIN = -(2^(N-1)-1);
  - FSM state encoding (3-bit: REPOSO, T0, T1, T2, FIN).
- One sub-module: multiplicacion_sat (parameters N, F; combinational sat_mul as above). It is reused later by the filter stages.
- The adder is the team's existing saturating adder module, instantiated once. Its output drives acc's D input.

Test Plan:
- Reset then idle: check U=0, listo=1, valido=0. K0=32768, K1=K2=0, inicio with error=100 -> valido at edge+4, U=100. Second inicio with error=100 -> U=200.
- History: K0=0, K1=32768, K2=0, error sequence 10, 20, 30 -> U = 0, 10, 30. Then K1=0, K2=32768 with a fresh reset, sequence 10, 20, 30 -> U = 0, 0, 10.
- Fractional truncation: K0=16384 (0.5), error=-3 -> product -2 (floor of -1.5), U=-2.
- Overflow: K0=error=16777215 -> product saturates to 16777215, U=16777215. Repeat with error=-16777215 -> U=0. A further negative sample -> U saturates at -16777215.
- Busy strobe: pulse inicio in T0 and T2 -> ignored. Exactly one valido; history advances by one sample.
- Async reset asserted during T1, no clock edge needed -> U=0, listo=1, valido=0, history cleared. The next sample behaves as the first after reset.
